wb_arb2_sdram: RTL

//  Two-master Wishbone arbiter that shares the memory_controller Wishbone slave port.

---
 rtl/wb_arb2_sdram_if.sv | 28 ++
 rtl/wb_arb2_sdram.sv | 129 ++++++++++++
 2 files changed

// File: rtl/wb_arb2_sdram_if.sv
// Wishbone B4 classic bus bundle shared by the two masters and the
// memory-controller port of the arbiter.
`timescale 1ns/1ps
interface wb_arb2_sdram_if #(
    parameter int dw     = 32,
    parameter int APP_AW = 26
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [APP_AW-1:0] addr;
    logic [dw-1:0]     dat_w;
    logic [dw/8-1:0]   sel;
    logic [2:0]        cti;
    logic              ack;
    logic              err;
    logic [dw-1:0]     dat_r;

    modport master (
        output cyc, stb, we, addr, dat_w, sel, cti,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, addr, dat_w, sel, cti,
        output ack, err, dat_r
    );
endinterface

// File: rtl/wb_arb2_sdram.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller port.
// Grant is held for a whole cyc, gated by SDRAM init, and guarded by an ack watchdog.
`timescale 1ns/1ps
module wb_arb2_sdram #(
    parameter int TIMEOUT = 255
) (
    input  logic            sys_clk,
    input  logic            sys_resetn,
    input  logic            sdr_init_done,
    wb_arb2_sdram_if.slave  m0,
    wb_arb2_sdram_if.slave  m1,
    wb_arb2_sdram_if.master s,
    output logic [1:0]      grant_o,
    output logic            timeout_o
);
    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABRT0, ABRT1} state_t;

    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

    state_t     state, state_next;
    logic       last;
    logic [7:0] wdog;
    logic       abort;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state     <= IDLE;
            last      <= 1'b1;
            wdog      <= '0;
            timeout_o <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register below sees the pre-edge values.
            state <= state_next;
            if (state_next == GNT0 && state != GNT0)
                last <= 1'b0;
            else if (state_next == GNT1 && state != GNT1)
                last <= 1'b1;
            if (state_next != state || s.ack || !s.stb)
                wdog <= '0;
            else
                wdog <= wdog + 8'd1;
            if (abort)
                timeout_o <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (sdr_init_done) begin
                    if (m0.cyc && m1.cyc)
                        state_next = last ? GNT0 : GNT1;
                    else if (m0.cyc)
                        state_next = GNT0;
                    else if (m1.cyc)
                        state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_next = IDLE;
                end else if (s.stb && wdog == WDOG_LIMIT && !s.ack) begin
                    abort      = 1'b1;
                    state_next = ABRT0;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_next = IDLE;
                end else if (s.stb && wdog == WDOG_LIMIT && !s.ack) begin
                    abort      = 1'b1;
                    state_next = ABRT1;
                end
            end
            ABRT0:   if (!m0.cyc) state_next = IDLE;
            ABRT1:   if (!m1.cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus steering depends only on the registered state, so an async reset
    // drops s.cyc immediately; abort states and IDLE leave everything at zero.
    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.addr   = '0;
        s.dat_w  = '0;
        s.sel    = '0;
        s.cti    = '0;
        m0.ack   = 1'b0;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.dat_r = '0;
        case (state)
            GNT0: begin
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.addr   = m0.addr;
                s.dat_w  = m0.dat_w;
                s.sel    = m0.sel;
                s.cti    = m0.cti;
                m0.ack   = s.ack;
                m0.dat_r = s.dat_r;
            end
            GNT1: begin
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.addr   = m1.addr;
                s.dat_w  = m1.dat_w;
                s.sel    = m1.sel;
                s.cti    = m1.cti;
                m1.ack   = s.ack;
                m1.dat_r = s.dat_r;
            end
            default: ;
        endcase
    end

    assign m0.err  = abort && (state == GNT0);
    assign m1.err  = abort && (state == GNT1);
    assign grant_o = {state == GNT1, state == GNT0};

endmodule
